// File: rtl/dmem_arb_pkg.sv
// Purpose: shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // Burst counter only has to reach MAX_BURST-1; keep at least one bit.
    function automatic int bcnt_w(input int max_burst);
        return (max_burst > 2) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Purpose: combinational two-way picker, one-hot winner from requests and round-robin pointer.
// Latency: purely combinational.
// Backpressure: a losing requester simply sees no win and keeps requesting.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       rr_ptr,
    output logic [1:0] win
);

    // Tie goes to requester 0 under fixed priority, else to the pointer's owner.
    always_comb begin
        win = 2'b00;
        if (req0 && req1) begin
            win = ((FIXED_PRIO != 0) || (rr_ptr == REQ_CPU)) ? 2'b01 : 2'b10;
        end else begin
            win = {req1, req0};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter for CPU/DMA access to a single-port data memory, with bounded locked bursts.
// Latency: grant combinational (0 cycles uncontested); read data/rvalid 1 cycle after accept.
// Backpressure: requester holds req until gnt; DMEM_ARB_STATS_EN adds grant/conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1,
    output logic [31:0]       conflict_cnt
`endif
);

    localparam int            BW        = bcnt_w(MAX_BURST);
    localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        win;
    logic              acc0, acc1;

    dmem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req0   (req0),
        .req1   (req1),
        .rr_ptr (rr_ptr_q),
        .win    (win)
    );

    // Next-state, grant and burst bookkeeping; grants are suppressed while in reset.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        case (state_q)
            IDLE: begin
                gnt0 = win[0];
                gnt1 = win[1];
                if (win[0]) begin
                    if (lock0 && (MAX_BURST > 1)) begin
                        state_d     = OWN0;
                        burst_cnt_d = BW'(1);
                    end else begin
                        rr_ptr_d = REQ_DMA;
                    end
                end else if (win[1]) begin
                    if (lock1 && (MAX_BURST > 1)) begin
                        state_d     = OWN1;
                        burst_cnt_d = BW'(1);
                    end else begin
                        rr_ptr_d = REQ_CPU;
                    end
                end
            end
            OWN0: begin
                gnt0 = req0;
                if (req0 && lock0 && (burst_cnt_q < BCNT_LAST)) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = REQ_DMA;
                end
            end
            OWN1: begin
                gnt1 = req1;
                if (req1 && lock1 && (burst_cnt_q < BCNT_LAST)) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = REQ_CPU;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign acc0 = req0 & gnt0;
    assign acc1 = req1 & gnt1;

    // Memory-side mux driven by whichever requester holds the grant.
    always_comb begin
        mem_addr = '0;
        mem_wd   = '0;
        mem_we   = 1'b0;
        if (gnt0) begin
            mem_addr = addr0;
            mem_wd   = wdata0;
            mem_we   = acc0 & we0;
        end else if (gnt1) begin
            mem_addr = addr1;
            mem_wd   = wdata1;
            mem_we   = acc1 & we1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= REQ_CPU;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Read response: capture memory data at the accepting edge, pulse rvalid for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid0_q <= acc0 & ~we0;
            rvalid1_q <= acc1 & ~we1;
            if ((acc0 & ~we0) | (acc1 & ~we1)) begin
                rdata_q <= mem_rd;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt1_q, conflict_cnt_q;

    // Accept and conflict counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (acc0) gnt_cnt0_q <= gnt_cnt0_q + 32'd1;
            if (acc1) gnt_cnt1_q <= gnt_cnt1_q + 32'd1;
            if (req0 && req1 && (gnt0 ^ gnt1)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed self-checking bench for dmem_arbiter (round-robin and fixed-priority instances).
// Latency: checks 0-cycle grant and 1-cycle read return.
// Backpressure: exercises held requests, locked bursts and reset mid-burst.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
    logic        gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, mem_we_f;
    logic [31:0] rdata_f, mem_addr_f, mem_wd_f, mem_rd_f;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
    logic [31:0] gnt_cnt0_f, gnt_cnt1_f, conflict_cnt_f;
`endif

    logic [31:0] mem [256];
    logic        init_phase = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Memory model: preload a known pattern, then behave as posedge-write / comb-read RAM.
    always @(posedge clk) begin
        if (init_phase) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wd;
        end
    end
    assign mem_rd   = mem[mem_addr[9:2]];
    assign mem_rd_f = mem_addr_f ^ 32'h0F0F_0F0F;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0_f), .gnt1(gnt1_f),
        .rvalid0(rvalid0_f), .rvalid1(rvalid1_f), .rdata(rdata_f), .mem_we(mem_we_f),
        .mem_addr(mem_addr_f), .mem_wd(mem_wd_f), .mem_rd(mem_rd_f)
`ifdef DMEM_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0_f), .gnt_cnt1(gnt_cnt1_f), .conflict_cnt(conflict_cnt_f)
`endif
    );

    // Inputs change 1 time unit after each rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        init_phase = 1'b0;
        req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'h1234_5678;
        tick();
        #1;
        n_cmp++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if (gnt0 !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: gnt0=%b mem_we=%b want 0 0", gnt0, mem_we); end
        n_cmp++; if (dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b0) begin n_fail++; $display("FAIL reset_state: state=%0d rr=%b want 0 0", dut.state_q, dut.rr_ptr_q); end
        reset = 1'b0;
        clear_inputs();
        tick();
        #1;
        n_cmp++; if (mem[16] !== 32'h1000_0010) begin n_fail++; $display("FAIL reset_nowrite: got %h want 10000010", mem[16]); end
    endtask

    task automatic test_write_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got %b%b want 10", gnt0, gnt1); end
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_mux: we=%b a=%h d=%h want 1 10 deadbeef", mem_we, mem_addr, mem_wd); end
        tick();
        we0 = 0;
        #1;
        n_cmp++; if (gnt0 !== 1'b1 || mem_we !== 1'b0 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rd_issue: gnt0=%b we=%b rv0=%b want 1 0 0", gnt0, mem_we, rvalid0); end
        tick();
        req0 = 0;
        #1;
        n_cmp++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_return: rv=%b%b rdata=%h want 10 deadbeef", rvalid0, rvalid1, rdata); end
        n_cmp++; if (mem_addr !== 32'h0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL idle_mux: addr=%h gnt0=%b want 0 0", mem_addr, gnt0); end
        tick();
        #1;
        n_cmp++; if (rvalid0 !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_hold: rv0=%b rdata=%h want 0 deadbeef", rvalid0, rdata); end
    endtask

    task automatic test_round_robin();
        logic e0;
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h0C; addr1 = 32'h24;
        for (int k = 0; k < 8; k++) begin
            #1;
            e0 = ((k % 2) == 0);
            n_cmp++; if (gnt0 !== e0 || gnt1 !== ~e0) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", k, gnt0, gnt1, e0, ~e0); end
            if (k > 0) begin
                n_cmp++;
                if (rvalid0 !== ~e0 || rvalid1 !== e0 || rdata !== (e0 ? 32'h1000_0009 : 32'h1000_0003)) begin
                    n_fail++; $display("FAIL rr_resp[%0d]: rv=%b%b rdata=%h want %b%b %h", k, rvalid0, rvalid1, rdata, ~e0, e0, e0 ? 32'h1000_0009 : 32'h1000_0003);
                end
            end
            tick();
        end
        clear_inputs();
        #1;
        n_cmp++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 32'h1000_0009) begin n_fail++; $display("FAIL rr_last: rv=%b%b rdata=%h want 01 10000009", rvalid0, rvalid1, rdata); end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h0C; addr1 = 32'h24;
        for (int k = 0; k < 10; k++) tick();
        clear_inputs();
        #1;
        n_cmp++; if (gnt_cnt0 !== 32'd5 || gnt_cnt1 !== 32'd5) begin n_fail++; $display("FAIL stats_gnt: got %0d %0d want 5 5", gnt_cnt0, gnt_cnt1); end
        n_cmp++; if (conflict_cnt !== 32'd10) begin n_fail++; $display("FAIL stats_conflict: got %0d want 10", conflict_cnt); end
    endtask
`endif

    task automatic test_burst();
        logic [7:0] pat0;
        pat0 = 8'b1110_1111;
        do_reset();
        req0 = 1; lock0 = 1; req1 = 1; addr0 = 32'h00; addr1 = 32'h04;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (gnt0 !== pat0[k] || gnt1 !== ~pat0[k]) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b%b want %b%b", k, gnt0, gnt1, pat0[k], ~pat0[k]); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_burst();
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 32'h28;
        #1;
        n_cmp++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL rb_first: got %b%b want 01", gnt0, gnt1); end
        tick();
        #1;
        n_cmp++; if (dut.state_q !== OWN1 || gnt1 !== 1'b1 || rvalid1 !== 1'b1) begin n_fail++; $display("FAIL rb_own: state=%0d gnt1=%b rv1=%b want 2 1 1", dut.state_q, gnt1, rvalid1); end
        reset = 1'b1;
        #1;
        n_cmp++; if (gnt1 !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rb_gnt_in_reset: gnt1=%b we=%b want 0 0", gnt1, mem_we); end
        tick();
        we1 = 1; addr1 = 32'h30; wdata1 = 32'h55AA_55AA;
        #1;
        n_cmp++; if (rvalid1 !== 1'b0 || dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b0 || dut.burst_cnt_q !== 2'd0) begin
            n_fail++; $display("FAIL rb_after: rv1=%b state=%0d rr=%b cnt=%0d want 0 0 0 0", rvalid1, dut.state_q, dut.rr_ptr_q, dut.burst_cnt_q);
        end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rb_we: got %b want 0", mem_we); end
        tick();
        reset = 1'b0;
        clear_inputs();
        tick();
        #1;
        n_cmp++; if (mem[12] !== 32'h1000_000C) begin n_fail++; $display("FAIL rb_nowrite: got %h want 1000000c", mem[12]); end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h08; addr1 = 32'h14;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (gnt0_f !== 1'b1 || gnt1_f !== 1'b0) begin n_fail++; $display("FAIL fp_gnt[%0d]: got %b%b want 10", k, gnt0_f, gnt1_f); end
            tick();
        end
        #1;
        n_cmp++; if (rvalid0_f !== 1'b1 || rvalid1_f !== 1'b0 || rdata_f !== (32'h08 ^ 32'h0F0F_0F0F)) begin n_fail++; $display("FAIL fp_resp: rv=%b%b rdata=%h want 10 0f0f0f07", rvalid0_f, rvalid1_f, rdata_f); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req0 = 1;
        for (int k = 0; k < 4; k++) begin
            addr0 = k * 4;
            #1;
            n_cmp++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, gnt0); end
            if (k > 0) begin
                n_cmp++; if (rvalid0 !== 1'b1 || rdata !== (32'h1000_0000 | (k - 1))) begin n_fail++; $display("FAIL b2b_resp[%0d]: rv0=%b rdata=%h want 1 %h", k, rvalid0, rdata, 32'h1000_0000 | (k - 1)); end
            end
            tick();
        end
        clear_inputs();
        #1;
        n_cmp++; if (rvalid0 !== 1'b1 || rdata !== 32'h1000_0003) begin n_fail++; $display("FAIL b2b_last: rv0=%b rdata=%h want 1 10000003", rvalid0, rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        test_burst();
        test_reset_in_burst();
        test_fixed_prio();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
